// File: rtl/magnetron_scheduler_if.sv
// Controller <-> power scheduler bundle: cooking commands in,
// power-stage enables and state code out.
interface magnetron_scheduler_if;
  logic       run;
  logic       hold;
  logic       porta;
  logic [1:0] potencia;
  logic       cook_done;
  logic       magnetron_on;
  logic       turntable_on;
  logic       fan_on;
  logic       beep;
  logic [2:0] status;

  modport master (
    output run, hold, porta, potencia, cook_done,
    input  magnetron_on, turntable_on, fan_on, beep, status
  );

  modport slave (
    input  run, hold, porta, potencia, cook_done,
    output magnetron_on, turntable_on, fan_on, beep, status
  );
endinterface

// File: rtl/magnetron_scheduler.sv
// Microwave power sequencer: spin-up, duty-cycled heat, pause, cool-down.
// Optional BEEP_EN adds a 3-beep end-of-cook sequence.
module magnetron_scheduler #(
  parameter int TICK_DIV = 100000000,
  parameter int PERIOD_T = 10,
  parameter int ON_T1    = 3,
  parameter int ON_T2    = 6,
  parameter int ON_T3    = 10,
  parameter int SPINUP_T = 2,
  parameter int COOL_T   = 5
) (
  input logic clock,
  input logic reset,
  magnetron_scheduler_if.slave bus
);
  localparam int TMAX = (SPINUP_T > COOL_T) ? SPINUP_T : COOL_T;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int HW   = $clog2(PERIOD_T + 1);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int L1   = (ON_T1 > PERIOD_T) ? PERIOD_T : ON_T1;
  localparam int L2   = (ON_T2 > PERIOD_T) ? PERIOD_T : ON_T2;
  localparam int L3   = (ON_T3 > PERIOD_T) ? PERIOD_T : ON_T3;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] PH_MAX  = HW'(PERIOD_T - 1);
  localparam logic [TW-1:0] SP_END  = TW'(SPINUP_T - 1);
  localparam logic [TW-1:0] CL_END  = TW'(COOL_T - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPIN  = 3'd1,
    S_HEAT  = 3'd2,
    S_PAUSE = 3'd3,
    S_COOL  = 3'd4
  } state_t;

  state_t        st, st_n;
  logic [PW-1:0] pre, pre_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [HW-1:0] ph, ph_n;
  logic [HW-1:0] lim, lim_n, lim_sel;
  logic          tick, running;
  logic          mag_req, turn_q, fan_q;

  assign running = (st == S_SPIN) || (st == S_HEAT) || (st == S_COOL);
  assign tick    = running && (pre == PRE_MAX);

  always_comb begin
    lim_sel = '0;
    unique case (bus.potencia)
      2'd0: lim_sel = '0;
      2'd1: lim_sel = HW'(L1);
      2'd2: lim_sel = HW'(L2);
      2'd3: lim_sel = HW'(L3);
      default: lim_sel = '0;
    endcase
  end

  // Door-open and run-drop win over timer expiry in every state.
  always_comb begin
    st_n = st;
    unique case (st)
      S_IDLE:
        if (bus.run && !bus.porta) st_n = S_SPIN;
      S_SPIN:
        if (!bus.run) st_n = S_COOL;
        else if (bus.porta || bus.hold) st_n = S_PAUSE;
        else if (tick && tmr == SP_END) st_n = S_HEAT;
      S_HEAT:
        if (!bus.run) st_n = S_COOL;
        else if (bus.porta || bus.hold) st_n = S_PAUSE;
      S_PAUSE:
        if (!bus.run) st_n = S_COOL;
        else if (!bus.hold && !bus.porta) st_n = S_HEAT;
      S_COOL:
        if (bus.run && !bus.porta) st_n = S_SPIN;
        else if (tick && tmr == CL_END) st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  always_comb begin
    pre_n = pre;
    tmr_n = tmr;
    ph_n  = ph;
    lim_n = lim;
    if (st_n != st) begin
      pre_n = '0;
      tmr_n = '0;
    end else if (running) begin
      if (tick) begin
        pre_n = '0;
        if (st != S_HEAT) tmr_n = tmr + 1'b1;
      end else begin
        pre_n = pre + 1'b1;
      end
    end
    // Power level is sampled only at period boundaries.
    if (st == S_SPIN && st_n == S_HEAT) begin
      ph_n  = '0;
      lim_n = lim_sel;
    end else if (st == S_HEAT && st_n == S_HEAT && tick) begin
      if (ph == PH_MAX) begin
        ph_n  = '0;
        lim_n = lim_sel;
      end else begin
        ph_n = ph + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= S_IDLE;
      pre     <= '0;
      tmr     <= '0;
      ph      <= '0;
      lim     <= '0;
      mag_req <= 1'b0;
      turn_q  <= 1'b0;
      fan_q   <= 1'b0;
    end else begin
      st      <= st_n;
      pre     <= pre_n;
      tmr     <= tmr_n;
      ph      <= ph_n;
      lim     <= lim_n;
      mag_req <= (st_n == S_HEAT) && (ph_n < lim_n);
      turn_q  <= (st_n == S_SPIN) || (st_n == S_HEAT);
      fan_q   <= (st_n != S_IDLE);
    end
  end

  // Door gate is combinational so the magnetron drops in the same cycle.
  assign bus.magnetron_on = mag_req && (st == S_HEAT) && !bus.porta;
  assign bus.turntable_on = turn_q;
  assign bus.fan_on       = fan_q;
  assign bus.status       = st;

`ifdef BEEP_EN
  logic [PW-1:0] bpre;
  logic [2:0]    bstep;
  logic          bact, beep_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bpre   <= '0;
      bstep  <= '0;
      bact   <= 1'b0;
      beep_q <= 1'b0;
    end else if (bus.cook_done) begin
      bpre   <= '0;
      bstep  <= '0;
      bact   <= 1'b1;
      beep_q <= 1'b1;
    end else if (bact) begin
      if (bpre == PRE_MAX) begin
        bpre <= '0;
        if (bstep == 3'd5) begin
          bact   <= 1'b0;
          beep_q <= 1'b0;
        end else begin
          bstep  <= bstep + 1'b1;
          beep_q <= bstep[0];
        end
      end else begin
        bpre <= bpre + 1'b1;
      end
    end
  end

  assign bus.beep = beep_q;
`else
  logic unused_cook_done;
  assign unused_cook_done = bus.cook_done;
  assign bus.beep = 1'b0;
`endif
endmodule
